// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, fetch status codes, the F/D record and the
// instruction-length helper used by the fetch stage and its aligner.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_STOP = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } fd_reg_t;

    localparam fd_reg_t FD_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    REG_NONE,
        rb:    REG_NONE,
        valc:  64'h0,
        valp:  64'h0
    };

    // Unknown icodes count as one byte so the bad opcode alone is addressed.
    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: instr_len = 4'd2;
            I_JXX, I_CALL:                    instr_len = 4'd9;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     instr_len = 4'd10;
            default:                          instr_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/y86_instr_align.sv
// Combinational aligner/decoder: splits ten raw instruction bytes starting at
// f_pc into Y86-64 fields, the sequential successor and the fetch status.
module y86_instr_align
    import y86_pkg::*;
#(
    parameter int IMEM_BYTES = 1024
) (
    input  logic [79:0] raw,
    input  logic [63:0] f_pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [63:0] valp,
    output logic        need_regids,
    output logic        need_valc,
    output logic [2:0]  stat
);

    logic [3:0]  raw_icode;
    logic [3:0]  raw_ifun;
    logic [3:0]  len;
    logic [64:0] last_byte;
    logic        ifun_ok;
    logic        adr_err;
    logic        ins_err;

    assign raw_icode = raw[7:4];
    assign raw_ifun  = raw[3:0];
    assign len       = instr_len(raw_icode);

    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        case (raw_icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: need_regids = 1'b1;
            default:                need_regids = 1'b0;
        endcase
        case (raw_icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_JXX, I_CALL:          need_valc = 1'b1;
            default:                need_valc = 1'b0;
        endcase
    end

    always_comb begin
        ifun_ok = 1'b0;
        case (raw_icode)
            I_RRMOVQ, I_JXX: ifun_ok = (raw_ifun <= 4'd6);
            I_OPQ:           ifun_ok = (raw_ifun <= 4'd3);
            default:         ifun_ok = (raw_ifun == 4'd0);
        endcase
    end

    // 65-bit sum so an instruction straddling 2^64 wraps into the carry bit
    // and is caught by the same bound check as a plain overrun.
    assign last_byte = {1'b0, f_pc} + {61'h0, len} - 65'd1;
    assign adr_err   = (last_byte >= 65'(IMEM_BYTES));
    assign ins_err   = (raw_icode > I_POPQ) || !ifun_ok;

    assign icode = raw_icode;
    assign ifun  = raw_ifun;
    assign valp  = f_pc + {60'h0, len};

    always_comb begin
        ra   = REG_NONE;
        rb   = REG_NONE;
        valc = 64'h0;
        if (!adr_err && !ins_err) begin
            if (need_regids) begin
                ra = raw[15:12];
                rb = raw[11:8];
            end
            if (raw_icode == I_JXX || raw_icode == I_CALL) begin
                valc = raw[71:8];
            end else if (need_valc) begin
                valc = raw[79:16];
            end
        end
    end

    always_comb begin
        if (adr_err) begin
            stat = STAT_ADR;
        end else if (ins_err) begin
            stat = STAT_INS;
        end else if (raw_icode == I_HALT) begin
            stat = STAT_HLT;
        end else begin
            stat = STAT_AOK;
        end
    end

endmodule

// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: instruction memory, PC selection, predPC, RUN/STOP state
// and the F/D register. Define FETCH_IMEM_LOAD_EN for the byte-write load port.
module y86_fetch_stage
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter string       INIT_FILE  = ""
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          F_stall,
    input  logic                          D_stall,
    input  logic                          D_bubble,
    input  logic [3:0]                    M_icode,
    input  logic                          M_Cnd,
    input  logic [63:0]                   M_valA,
    input  logic [3:0]                    W_icode,
    input  logic [63:0]                   W_valM,
`ifdef FETCH_IMEM_LOAD_EN
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
    input  logic [7:0]                    imem_wdata,
`endif
    output logic [63:0]                   f_pc,
    output logic [2:0]                    D_stat,
    output logic [3:0]                    D_icode,
    output logic [3:0]                    D_ifun,
    output logic [3:0]                    D_rA,
    output logic [3:0]                    D_rB,
    output logic [63:0]                   D_valC,
    output logic [63:0]                   D_valP
);

    localparam int AW = $clog2(IMEM_BYTES);

    logic [7:0]   mem [IMEM_BYTES];
    logic [63:0]  pred_pc;
    fetch_state_t state;
    fd_reg_t      fd_q;
    fd_reg_t      fetched;

    logic         mispredict;
    logic         ret_taken;
    logic         fetch_live;
    logic [79:0]  raw;

    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [63:0]  valc;
    logic [63:0]  valp;
    logic [2:0]   stat;
    logic         need_regids;
    logic         need_valc;
    logic         unused_hints;

`ifdef FETCH_IMEM_LOAD_EN
    initial begin
        for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'h00;
    end

    // Load port lands at the edge, so a same-cycle fetch still sees old data.
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end
`else
    initial begin
        for (int i = 0; i < IMEM_BYTES; i++) mem[i] = 8'h00;
    end
`endif

    assign mispredict = (M_icode == I_JXX) && !M_Cnd;
    assign ret_taken  = (W_icode == I_RET);
    assign f_pc       = mispredict ? M_valA : (ret_taken ? W_valM : pred_pc);

    // A correction revives a stopped fetch in the very cycle it arrives.
    assign fetch_live = (state == FS_RUN) || mispredict || ret_taken;

    for (genvar i = 0; i < 10; i++) begin : g_rd
        logic [63:0] addr;
        assign addr = f_pc + 64'(i);
        assign raw[8*i +: 8] = (addr < 64'(IMEM_BYTES)) ? mem[addr[AW-1:0]] : 8'h00;
    end

    y86_instr_align #(
        .IMEM_BYTES(IMEM_BYTES)
    ) u_align (
        .raw        (raw),
        .f_pc       (f_pc),
        .icode      (icode),
        .ifun       (ifun),
        .ra         (ra),
        .rb         (rb),
        .valc       (valc),
        .valp       (valp),
        .need_regids(need_regids),
        .need_valc  (need_valc),
        .stat       (stat)
    );

    // Field-presence hints are for downstream decode, fetch does not need them.
    assign unused_hints = need_regids ^ need_valc;

    assign fetched = '{
        stat:  stat,
        icode: icode,
        ifun:  ifun,
        ra:    ra,
        rb:    rb,
        valc:  valc,
        valp:  valp
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_pc <= RESET_PC;
            state   <= FS_RUN;
        end else if (!F_stall && fetch_live) begin
            pred_pc <= (icode == I_JXX || icode == I_CALL) ? valc : valp;
            state   <= (stat == STAT_AOK) ? FS_RUN : FS_STOP;
        end
    end

    // ---- F/D pipeline register boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fd_q <= FD_BUBBLE;
        end else if (!D_stall) begin
            if (D_bubble || !fetch_live) begin
                fd_q <= FD_BUBBLE;
            end else begin
                fd_q <= fetched;
            end
        end
    end

    assign D_stat  = fd_q.stat;
    assign D_icode = fd_q.icode;
    assign D_ifun  = fd_q.ifun;
    assign D_rA    = fd_q.ra;
    assign D_rB    = fd_q.rb;
    assign D_valC  = fd_q.valc;
    assign D_valP  = fd_q.valp;

endmodule
